// File: rtl/down_timer.sv
// Loadable synchronous down-counter/timer with one-shot and auto-reload modes.
// Emits a registered one-cycle terminal-count pulse when the count expires.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] reload_r, reload_s;
  logic             tc_r, tc_s;

  // Next-state, next-count and terminal-count decode; load beats everything but reset.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    if (load) begin
      count_s  = load_val;
      reload_s = load_val;
      if (load_val == ZERO_C) begin
        state_s = DONE;
      end else begin
        state_s = RUN;
      end
    end else begin
      case (state_r)
        IDLE: begin
          count_s = ZERO_C;
        end
        RUN: begin
          if (!en) begin
            count_s = count_r;
          end else if (count_r == ONE_C) begin
            // auto_reload only matters here, at the terminal event
            tc_s = 1'b1;
            if (auto_reload) begin
              count_s = reload_r;
            end else begin
              count_s = ZERO_C;
              state_s = DONE;
            end
          end else if (count_r != ZERO_C) begin
            count_s = count_r - ONE_C;
          end else begin
            state_s = DONE;
          end
        end
        DONE: begin
          count_s = ZERO_C;
        end
        default: begin
          state_s = IDLE;
          count_s = ZERO_C;
        end
      endcase
    end
  end

  // State, counter, reload value and tc pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= ZERO_C;
      reload_r <= ZERO_C;
      tc_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign zero  = (count_r == ZERO_C);
  assign busy  = (state_r == RUN);

endmodule
